// File: rtl/pll_pkg.sv
// -----------------------------------------------------------------------------
// pll_pkg
// Shared types and constants for the PLL lock sequencer.
//   - pll_state_e : 3-bit FSM state codes, also driven out on state_out
//   - CNT_W       : width of the shared per-state cycle counter
//   - LOSS_W      : width of the saturating lock-loss event counter
//   - sat_inc_loss: saturating increment used for the lock-loss counter
// -----------------------------------------------------------------------------
package pll_pkg;

    localparam int CNT_W   = 16;
    localparam int LOSS_W  = 8;
    localparam int IDX_W   = 3;   // covers stage indices 0..7
    localparam int RETRY_W = 8;
    localparam int STATE_W = 3;

    localparam logic [CNT_W-1:0]   CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]   CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0]   IDX_ZERO   = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0]   IDX_ONE    = {{(IDX_W-1){1'b0}}, 1'b1};
    localparam logic [RETRY_W-1:0] RETRY_ZERO = {RETRY_W{1'b0}};
    localparam logic [RETRY_W-1:0] RETRY_ONE  = {{(RETRY_W-1){1'b0}}, 1'b1};
    localparam logic [LOSS_W-1:0]  LOSS_ZERO  = {LOSS_W{1'b0}};
    localparam logic [LOSS_W-1:0]  LOSS_ONE   = {{(LOSS_W-1){1'b0}}, 1'b1};
    localparam logic [LOSS_W-1:0]  LOSS_MAX   = {LOSS_W{1'b1}};

    typedef enum logic [STATE_W-1:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_RUN       = 3'd4,
        ST_FAIL      = 3'd5
    } pll_state_e;

    // Saturating increment: the loss counter sticks at all-ones so that a
    // flapping PLL stays visible instead of wrapping back to a small value.
    function automatic logic [LOSS_W-1:0] sat_inc_loss(input logic [LOSS_W-1:0] v);
        logic [LOSS_W-1:0] r;
        if (v == LOSS_MAX) begin
            r = v;
        end else begin
            r = v + LOSS_ONE;
        end
        return r;
    endfunction

endpackage

// File: rtl/pll_lock_sequencer_if.sv
// -----------------------------------------------------------------------------
// pll_lock_sequencer_if
// Bundle of the PLL supervision and staged-reset signals.
//   pll_lock_in     : PLL LOCK, asynchronous to the sequencer clock
//   restart_in      : single-cycle request to re-run the bring-up sequence
//   pll_resetb_out  : to PLL RESETB, active-low
//   stage_reset_out : active-high downstream resets, bit 0 released first
//   ready_out       : high only while the sequencer is in RUN
//   fail_out        : high only while the sequencer is in FAIL
//   state_out       : current FSM state code
//   loss_count_out  : saturating count of lock-loss events
// modport master is the sequencer side, modport slave the consumer side.
// -----------------------------------------------------------------------------
interface pll_lock_sequencer_if #(
    parameter int NUM_STAGES = 3
);
    import pll_pkg::*;

    logic                  pll_lock_in;
    logic                  restart_in;
    logic                  pll_resetb_out;
    logic [NUM_STAGES-1:0] stage_reset_out;
    logic                  ready_out;
    logic                  fail_out;
    logic [STATE_W-1:0]    state_out;
    logic [LOSS_W-1:0]     loss_count_out;

    modport master (
        input  pll_lock_in,
        input  restart_in,
        output pll_resetb_out,
        output stage_reset_out,
        output ready_out,
        output fail_out,
        output state_out,
        output loss_count_out
    );

    modport slave (
        output pll_lock_in,
        output restart_in,
        input  pll_resetb_out,
        input  stage_reset_out,
        input  ready_out,
        input  fail_out,
        input  state_out,
        input  loss_count_out
    );

endinterface

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// One-bit two-flop synchronizer with asynchronous active-low reset.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, both flops clear to 0
//   d     : asynchronous input
//   q     : synchronized output, two destination-clock cycles of latency
// -----------------------------------------------------------------------------
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // Two-stage capture; meta_r may go metastable, sync_r is the clean copy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/pll_lock_sequencer.sv
// -----------------------------------------------------------------------------
// pll_lock_sequencer
// Supervises the iCE40 PLL from the board reference clock: pulses RESETB,
// waits for LOCK with a timeout and retry limit, qualifies LOCK as stable,
// then releases the downstream resets one stage at a time. Lock loss or a
// restart request re-runs the whole sequence.
//   clk_in    : reference clock (keeps running while the PLL output is absent)
//   resetb_in : asynchronous active-low reset
//   seq_if    : master side of pll_lock_sequencer_if (lock/restart in,
//               RESETB, stage resets, ready/fail, state and loss count out)
// Stage resets live in the clk_in domain; consumers on the PLL clock must
// re-synchronize them locally.
// -----------------------------------------------------------------------------
module pll_lock_sequencer
    import pll_pkg::*;
#(
    parameter int RESET_CYCLES = 16,
    parameter int LOCK_TIMEOUT = 4096,
    parameter int LOCK_STABLE  = 256,
    parameter int NUM_STAGES   = 3,
    parameter int STAGE_GAP    = 8,
    parameter int MAX_RETRIES  = 4
) (
    input  logic                 clk_in,
    input  logic                 resetb_in,
    pll_lock_sequencer_if.master seq_if
);

    // Terminal counts: each state ends when cnt reaches its length minus one.
    localparam logic [CNT_W-1:0]      RST_LAST    = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0]      TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]      STABLE_LAST = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0]      GAP_LAST    = CNT_W'(STAGE_GAP - 1);
    localparam logic [RETRY_W-1:0]    RETRY_MAX   = RETRY_W'(MAX_RETRIES);
    localparam logic [IDX_W-1:0]      IDX_LAST    = IDX_W'(NUM_STAGES - 1);
    localparam logic [NUM_STAGES-1:0] STAGES_ON   = {NUM_STAGES{1'b1}};

    logic                  lock_s;
    logic                  retries_spent_s;

    pll_state_e            state_r;
    logic [CNT_W-1:0]      cnt_r;
    logic [RETRY_W-1:0]    retry_cnt_r;
    logic [IDX_W-1:0]      idx_r;
    logic                  pll_resetb_r;
    logic [NUM_STAGES-1:0] stage_reset_r;
    logic                  ready_r;
    logic                  fail_r;
    logic [LOSS_W-1:0]     loss_cnt_r;

    sync_2ff u_lock_sync (
        .clk   (clk_in),
        .rst_n (resetb_in),
        .d     (seq_if.pll_lock_in),
        .q     (lock_s)
    );

    // A failed attempt goes to FAIL once the retry budget is used up.
    assign retries_spent_s = (retry_cnt_r == RETRY_MAX);

    // Sequencer FSM; every output is a register updated here.
    always_ff @(posedge clk_in or negedge resetb_in) begin
        if (!resetb_in) begin
            state_r       <= ST_PLL_RST;
            cnt_r         <= CNT_ZERO;
            retry_cnt_r   <= RETRY_ZERO;
            idx_r         <= IDX_ZERO;
            pll_resetb_r  <= 1'b0;
            stage_reset_r <= STAGES_ON;
            ready_r       <= 1'b0;
            fail_r        <= 1'b0;
            loss_cnt_r    <= LOSS_ZERO;
        end else if (seq_if.restart_in) begin
            // Restart beats every other transition, including lock loss,
            // and deliberately leaves the loss counter alone.
            state_r       <= ST_PLL_RST;
            cnt_r         <= CNT_ZERO;
            retry_cnt_r   <= RETRY_ZERO;
            idx_r         <= IDX_ZERO;
            pll_resetb_r  <= 1'b0;
            stage_reset_r <= STAGES_ON;
            ready_r       <= 1'b0;
            fail_r        <= 1'b0;
        end else begin
            case (state_r)
                ST_PLL_RST: begin
                    stage_reset_r <= STAGES_ON;
                    ready_r       <= 1'b0;
                    fail_r        <= 1'b0;
                    if (cnt_r == RST_LAST) begin
                        state_r      <= ST_WAIT_LOCK;
                        cnt_r        <= CNT_ZERO;
                        pll_resetb_r <= 1'b1;
                    end else begin
                        cnt_r        <= cnt_r + CNT_ONE;
                        pll_resetb_r <= 1'b0;
                    end
                end

                ST_WAIT_LOCK: begin
                    if (lock_s) begin
                        state_r <= ST_STABLE;
                        cnt_r   <= CNT_ZERO;
                    end else if (cnt_r == TIMEOUT_LAST) begin
                        cnt_r        <= CNT_ZERO;
                        pll_resetb_r <= 1'b0;
                        if (retries_spent_s) begin
                            state_r <= ST_FAIL;
                            fail_r  <= 1'b1;
                        end else begin
                            state_r     <= ST_PLL_RST;
                            retry_cnt_r <= retry_cnt_r + RETRY_ONE;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end

                ST_STABLE: begin
                    if (!lock_s) begin
                        // A dropout while qualifying counts as a failed attempt.
                        cnt_r        <= CNT_ZERO;
                        pll_resetb_r <= 1'b0;
                        if (retries_spent_s) begin
                            state_r <= ST_FAIL;
                            fail_r  <= 1'b1;
                        end else begin
                            state_r     <= ST_PLL_RST;
                            retry_cnt_r <= retry_cnt_r + RETRY_ONE;
                        end
                    end else if (cnt_r == STABLE_LAST) begin
                        state_r <= ST_RELEASE;
                        cnt_r   <= CNT_ZERO;
                        idx_r   <= IDX_ZERO;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end

                ST_RELEASE: begin
                    if (!lock_s) begin
                        // Lock loss wins even over the final stage release.
                        state_r       <= ST_PLL_RST;
                        cnt_r         <= CNT_ZERO;
                        idx_r         <= IDX_ZERO;
                        pll_resetb_r  <= 1'b0;
                        stage_reset_r <= STAGES_ON;
                        ready_r       <= 1'b0;
                        loss_cnt_r    <= sat_inc_loss(loss_cnt_r);
                    end else if (cnt_r == GAP_LAST) begin
                        // Stages release in order from bit 0, so shifting a
                        // zero in from the bottom releases stage idx_r.
                        stage_reset_r <= stage_reset_r << 1;
                        cnt_r         <= CNT_ZERO;
                        if (idx_r == IDX_LAST) begin
                            state_r     <= ST_RUN;
                            ready_r     <= 1'b1;
                            retry_cnt_r <= RETRY_ZERO;
                            idx_r       <= IDX_ZERO;
                        end else begin
                            idx_r <= idx_r + IDX_ONE;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end

                ST_RUN: begin
                    if (!lock_s) begin
                        state_r       <= ST_PLL_RST;
                        cnt_r         <= CNT_ZERO;
                        idx_r         <= IDX_ZERO;
                        pll_resetb_r  <= 1'b0;
                        stage_reset_r <= STAGES_ON;
                        ready_r       <= 1'b0;
                        loss_cnt_r    <= sat_inc_loss(loss_cnt_r);
                    end else begin
                        ready_r <= 1'b1;
                    end
                end

                ST_FAIL: begin
                    // Sticky: only resetb_in or restart_in leave this state.
                    pll_resetb_r  <= 1'b0;
                    stage_reset_r <= STAGES_ON;
                    ready_r       <= 1'b0;
                    fail_r        <= 1'b1;
                end

                default: begin
                    // Unused codes recover into a clean bring-up.
                    state_r       <= ST_PLL_RST;
                    cnt_r         <= CNT_ZERO;
                    retry_cnt_r   <= RETRY_ZERO;
                    idx_r         <= IDX_ZERO;
                    pll_resetb_r  <= 1'b0;
                    stage_reset_r <= STAGES_ON;
                    ready_r       <= 1'b0;
                    fail_r        <= 1'b0;
                end
            endcase
        end
    end

    assign seq_if.pll_resetb_out  = pll_resetb_r;
    assign seq_if.stage_reset_out = stage_reset_r;
    assign seq_if.ready_out       = ready_r;
    assign seq_if.fail_out        = fail_r;
    assign seq_if.state_out       = state_r;
    assign seq_if.loss_count_out  = loss_cnt_r;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pll_lock_sequencer
// Directed bench for pll_lock_sequencer with RESET_CYCLES=4, LOCK_TIMEOUT=32,
// LOCK_STABLE=8, NUM_STAGES=3, STAGE_GAP=2, MAX_RETRIES=2. Inputs change and
// outputs are sampled on the falling clock edge; the DUT acts on rising edges.
// Lock changes reach the FSM on the third rising edge after they are driven
// (two synchronizer flops, then the FSM register).
// -----------------------------------------------------------------------------
module tb_pll_lock_sequencer;

    logic clk_in;
    logic resetb_in;
    int   n_checks;
    int   n_fails;

    pll_lock_sequencer_if #(.NUM_STAGES(3)) seq_if ();

    pll_lock_sequencer #(
        .RESET_CYCLES (4),
        .LOCK_TIMEOUT (32),
        .LOCK_STABLE  (8),
        .NUM_STAGES   (3),
        .STAGE_GAP    (2),
        .MAX_RETRIES  (2)
    ) dut (
        .clk_in    (clk_in),
        .resetb_in (resetb_in),
        .seq_if    (seq_if)
    );

    // 10 ns reference clock.
    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    task automatic check_value(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    // Bounded wait for a state code; an expired budget shows up as a mismatch.
    task automatic wait_state(input logic [2:0] code, input int budget, input string tag);
        int n;
        n = 0;
        while (seq_if.state_out !== code && n < budget) begin
            @(negedge clk_in);
            n++;
        end
        check_value(tag, 32'(seq_if.state_out), 32'(code));
    endtask

    initial begin
        int low_cnt;
        int runs_ok;
        int n;

        n_checks = 0;
        n_fails  = 0;
        resetb_in = 1'b0;
        seq_if.pll_lock_in = 1'b0;
        seq_if.restart_in  = 1'b0;

        // ---------------- reset values ----------------
        step(2);
        check_value("rst_state", 32'(seq_if.state_out), 32'd0);
        check_value("rst_pll_resetb", 32'(seq_if.pll_resetb_out), 32'd0);
        check_value("rst_stages", 32'(seq_if.stage_reset_out), 32'h7);
        check_value("rst_ready", 32'(seq_if.ready_out), 32'd0);
        check_value("rst_fail", 32'(seq_if.fail_out), 32'd0);
        check_value("rst_loss", 32'(seq_if.loss_count_out), 32'd0);

        // ---------------- 1: nominal bring-up ----------------
        resetb_in = 1'b1;
        low_cnt = 0;
        while (seq_if.pll_resetb_out == 1'b0 && low_cnt < 50) begin
            low_cnt++;
            step(1);
        end
        check_value("s1_resetb_low_cycles", 32'(low_cnt), 32'd4);
        check_value("s1_wait_lock", 32'(seq_if.state_out), 32'd1);
        step(10);
        seq_if.pll_lock_in = 1'b1;
        step(2);
        check_value("s1_still_waiting", 32'(seq_if.state_out), 32'd1);
        step(1);
        check_value("s1_stable_entry", 32'(seq_if.state_out), 32'd2);
        step(7);
        check_value("s1_stable_hold", 32'(seq_if.state_out), 32'd2);
        step(1);
        check_value("s1_release_entry", 32'(seq_if.state_out), 32'd3);
        check_value("s1_stages_111", 32'(seq_if.stage_reset_out), 32'h7);
        step(2);
        check_value("s1_stages_110", 32'(seq_if.stage_reset_out), 32'h6);
        step(1);
        check_value("s1_stages_110_hold", 32'(seq_if.stage_reset_out), 32'h6);
        step(1);
        check_value("s1_stages_100", 32'(seq_if.stage_reset_out), 32'h4);
        step(1);
        check_value("s1_ready_low_in_release", 32'(seq_if.ready_out), 32'd0);
        step(1);
        check_value("s1_stages_000", 32'(seq_if.stage_reset_out), 32'h0);
        check_value("s1_run", 32'(seq_if.state_out), 32'd4);
        check_value("s1_ready", 32'(seq_if.ready_out), 32'd1);
        check_value("s1_pll_resetb_high", 32'(seq_if.pll_resetb_out), 32'd1);

        // ---------------- 3: lock glitch in STABLE ----------------
        seq_if.pll_lock_in = 1'b0;
        seq_if.restart_in  = 1'b1;
        step(1);
        seq_if.restart_in  = 1'b0;
        check_value("s3_restart_state", 32'(seq_if.state_out), 32'd0);
        check_value("s3_restart_stages", 32'(seq_if.stage_reset_out), 32'h7);
        check_value("s3_restart_ready", 32'(seq_if.ready_out), 32'd0);
        check_value("s3_restart_loss", 32'(seq_if.loss_count_out), 32'd0);
        wait_state(3'd1, 20, "s3_wait_lock");
        seq_if.pll_lock_in = 1'b1;
        step(5);
        seq_if.pll_lock_in = 1'b0;
        step(2);
        check_value("s3_glitch_in_stable", 32'(seq_if.state_out), 32'd2);
        step(1);
        check_value("s3_glitch_to_pll_rst", 32'(seq_if.state_out), 32'd0);
        check_value("s3_retry_one", 32'(dut.retry_cnt_r), 32'd1);
        seq_if.pll_lock_in = 1'b1;
        wait_state(3'd4, 80, "s3_second_lock_run");
        check_value("s3_loss_zero", 32'(seq_if.loss_count_out), 32'd0);
        check_value("s3_retry_cleared", 32'(dut.retry_cnt_r), 32'd0);

        // ---------------- 4a: single lock loss in RUN ----------------
        seq_if.pll_lock_in = 1'b0;
        step(2);
        check_value("s4_run_before_sync", 32'(seq_if.ready_out), 32'd1);
        step(1);
        check_value("s4_loss_stages", 32'(seq_if.stage_reset_out), 32'h7);
        check_value("s4_loss_ready", 32'(seq_if.ready_out), 32'd0);
        check_value("s4_loss_state", 32'(seq_if.state_out), 32'd0);
        check_value("s4_loss_count", 32'(seq_if.loss_count_out), 32'd1);
        seq_if.pll_lock_in = 1'b1;
        wait_state(3'd4, 60, "s4_relock_run");

        // ---------------- 5: restart at final stage release ----------------
        seq_if.restart_in = 1'b1;
        step(1);
        seq_if.restart_in = 1'b0;
        check_value("s5_restart_from_run", 32'(seq_if.state_out), 32'd0);
        wait_state(3'd3, 60, "s5_release");
        step(5);
        check_value("s5_before_last", 32'(seq_if.stage_reset_out), 32'h4);
        seq_if.restart_in = 1'b1;
        step(1);
        seq_if.restart_in = 1'b0;
        check_value("s5_state", 32'(seq_if.state_out), 32'd0);
        check_value("s5_stages", 32'(seq_if.stage_reset_out), 32'h7);
        check_value("s5_ready", 32'(seq_if.ready_out), 32'd0);
        check_value("s5_loss_unchanged", 32'(seq_if.loss_count_out), 32'd1);

        // ---------------- lock loss at final stage release ----------------
        wait_state(3'd3, 60, "lf_release");
        step(3);
        seq_if.pll_lock_in = 1'b0;
        step(2);
        check_value("lf_before_last", 32'(seq_if.stage_reset_out), 32'h4);
        step(1);
        check_value("lf_state", 32'(seq_if.state_out), 32'd0);
        check_value("lf_stages", 32'(seq_if.stage_reset_out), 32'h7);
        check_value("lf_ready", 32'(seq_if.ready_out), 32'd0);
        check_value("lf_loss", 32'(seq_if.loss_count_out), 32'd2);

        // ---------------- 4b: repeated loss, counter saturation ----------------
        seq_if.pll_lock_in = 1'b1;
        wait_state(3'd4, 60, "s4b_run");
        runs_ok = 0;
        for (int i = 0; i < 298; i++) begin
            seq_if.pll_lock_in = 1'b0;
            step(3);
            seq_if.pll_lock_in = 1'b1;
            n = 0;
            while (seq_if.state_out !== 3'd4 && n < 60) begin
                step(1);
                n++;
            end
            if (seq_if.state_out === 3'd4) runs_ok++;
            if (i == 251) check_value("s4b_loss_254", 32'(seq_if.loss_count_out), 32'd254);
        end
        check_value("s4b_runs", 32'(runs_ok), 32'd298);
        check_value("s4b_loss_sat", 32'(seq_if.loss_count_out), 32'd255);

        // ---------------- 2: lock never rises ----------------
        seq_if.pll_lock_in = 1'b0;
        seq_if.restart_in  = 1'b1;
        step(1);
        seq_if.restart_in  = 1'b0;
        check_value("s2_start", 32'(seq_if.state_out), 32'd0);
        check_value("s2_loss_kept", 32'(seq_if.loss_count_out), 32'd255);
        step(35);
        check_value("s2_wait1_end", 32'(seq_if.state_out), 32'd1);
        step(1);
        check_value("s2_retry1", 32'(seq_if.state_out), 32'd0);
        step(3);
        check_value("s2_resetb_low4", 32'(seq_if.pll_resetb_out), 32'd0);
        step(1);
        check_value("s2_resetb_rise", 32'(seq_if.pll_resetb_out), 32'd1);
        step(67);
        check_value("s2_wait3_end", 32'(seq_if.state_out), 32'd1);
        step(1);
        check_value("s2_fail_state", 32'(seq_if.state_out), 32'd5);
        check_value("s2_fail_out", 32'(seq_if.fail_out), 32'd1);
        check_value("s2_fail_resetb", 32'(seq_if.pll_resetb_out), 32'd0);
        check_value("s2_fail_stages", 32'(seq_if.stage_reset_out), 32'h7);
        step(50);
        check_value("s2_fail_sticky", 32'(seq_if.state_out), 32'd5);
        seq_if.restart_in = 1'b1;
        step(1);
        seq_if.restart_in = 1'b0;
        check_value("s2_restart_state", 32'(seq_if.state_out), 32'd0);
        check_value("s2_restart_fail_out", 32'(seq_if.fail_out), 32'd0);

        // ---------------- 6: async reset mid-RELEASE ----------------
        seq_if.pll_lock_in = 1'b1;
        wait_state(3'd3, 60, "s6_release");
        step(2);
        check_value("s6_stages_110", 32'(seq_if.stage_reset_out), 32'h6);
        #1 resetb_in = 1'b0;
        #1;
        check_value("s6_state", 32'(seq_if.state_out), 32'd0);
        check_value("s6_pll_resetb", 32'(seq_if.pll_resetb_out), 32'd0);
        check_value("s6_stages", 32'(seq_if.stage_reset_out), 32'h7);
        check_value("s6_ready", 32'(seq_if.ready_out), 32'd0);
        check_value("s6_fail", 32'(seq_if.fail_out), 32'd0);
        check_value("s6_loss", 32'(seq_if.loss_count_out), 32'd0);
        step(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
